// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package program_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write side of the loader.
interface program_loader_if #(
  parameter int unsigned DATA_WIDTH = program_loader_pkg::WORD_W
) ();

  logic                  Start;
  logic [7:0]            ByteIn;
  logic                  ByteValid;
  logic                  ByteReady;
  logic                  WriteEnable;
  logic [DATA_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  CpuHold;
  logic                  Done;
  logic                  Error;

  modport master (
    output Start, ByteIn, ByteValid,
    input  ByteReady, WriteEnable, WriteAddress, WriteData, CpuHold, Done, Error
  );

  modport slave (
    input  Start, ByteIn, ByteValid,
    output ByteReady, WriteEnable, WriteAddress, WriteData, CpuHold, Done, Error
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts bytes MSB-first into a word; flags the accept that completes the word.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_full_c
);

  // Only the low three bytes are kept; the top byte is always the oldest.
  logic [WORD_W-BYTE_W-1:0] r_word;
  logic [IDX_W-1:0]         r_byte_idx;

  assign o_word_c      = {r_word, i_byte};
  assign o_word_full_c = i_load && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_word     <= o_word_c[WORD_W-BYTE_W-1:0];
      r_byte_idx <= IDX_W'(r_byte_idx + IDX_W'(1));
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed byte stream and writes it into program memory,
// holding the CPU in reset until the load completes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned       MEMORY_DEPTH = 32,
  parameter int unsigned       DATA_WIDTH   = WORD_W,
  parameter logic [WORD_W-1:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic               r_byte_ready;
  logic               r_we;
  logic               r_done;
  logic               r_error;
  logic               r_cpu_hold;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_count;
  mem_wr_t            r_wr;

  logic               w_accept;
  logic               w_load;
  logic               w_clear;
  logic [LEN_W-1:0]   w_len_c;
  logic [LEN_W-1:0]   w_count_inc;
  logic [WORD_W-1:0]  w_word_c;
  logic               w_word_full_c;

  assign w_accept    = bus.ByteValid && r_byte_ready;
  assign w_len_c     = {r_len[LEN_W-1:BYTE_W], bus.ByteIn};
  assign w_count_inc = LEN_W'(r_count + LEN_W'(1));

  word_assembler u_word_assembler (
    .clk           (clk),
    .rst_n         (reset),
    .i_clear       (w_clear),
    .i_load        (w_load),
    .i_byte        (bus.ByteIn),
    .o_word_c      (w_word_c),
    .o_word_full_c (w_word_full_c)
  );

  // Next-state and assembler control.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (bus.Start) w_next = LEN_HI;
      end
      LEN_HI: begin
        if (w_accept) w_next = LEN_LO;
      end
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_c == '0) begin
            w_next = DONE;
          end else if (w_len_c > LEN_W'(MEMORY_DEPTH)) begin
            w_next = ERROR;
          end else begin
            w_next  = DATA;
            w_clear = 1'b1;
          end
        end
      end
      DATA: begin
        w_load = w_accept;
        if (w_word_full_c) w_next = WRITE;
      end
      WRITE: begin
        if (w_count_inc == r_len) begin
          w_next = DONE;
        end else begin
          w_next  = DATA;
          w_clear = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, registered outputs and datapath; outputs decode the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_len        <= '0;
      r_count      <= '0;
      r_wr         <= '0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == LEN_HI) || (w_next == LEN_LO) || (w_next == DATA);
      r_we         <= (w_next == WRITE);
      r_done       <= (w_next == DONE);
      r_error      <= (w_next == ERROR);
      r_cpu_hold   <= (w_next != DONE);
      if (r_state == LEN_HI && w_accept) r_len[LEN_W-1:BYTE_W] <= bus.ByteIn;
      if (r_state == LEN_LO && w_accept) begin
        r_len[BYTE_W-1:0] <= bus.ByteIn;
        r_count           <= '0;
      end
      if (r_state == WRITE) r_count <= w_count_inc;
      if (w_word_full_c) begin
        r_wr.addr <= BASE_ADDRESS + WORD_W'({r_count, 2'b00});
        r_wr.data <= w_word_c;
      end
    end
  end

  assign bus.ByteReady    = r_byte_ready;
  assign bus.WriteEnable  = r_we;
  assign bus.WriteAddress = DATA_WIDTH'(r_wr.addr);
  assign bus.WriteData    = DATA_WIDTH'(r_wr.data);
  assign bus.CpuHold      = r_cpu_hold;
  assign bus.Done         = r_done;
  assign bus.Error        = r_error;

endmodule
